// File: rtl/iob_bootrom_rom_ctrl.sv
// Bootrom read controller: turns ren/raddr into a fixed-latency ROM access and a one-cycle rvalid pulse.
// Optional one-entry last-word cache enabled by defining IOB_BOOTROM_ROM_CTRL_CACHE_EN.
module iob_bootrom_rom_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rom_raddr_i,
  input  logic              rom_ren_i,
  output logic [DATA_W-1:0] rom_rdata_o,
  output logic              rom_rvalid_o,
  output logic              rom_rready_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("iob_bootrom_rom_ctrl: MEM_LAT must be in 1..4");
  end

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_lat_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic              w_accept;
  logic              w_hit;
  logic              w_miss;
  logic              w_capture;
  logic [DATA_W-1:0] w_hit_dat;

  // Reset wins over a coincident request, so it also suppresses the ROM enable.
  assign w_accept  = rom_ren_i & (r_state == S_IDLE) & cke_i & ~rst_i;
  assign w_miss    = w_accept & ~w_hit;
  assign w_capture = (r_state == S_BUSY) && (r_lat_cnt == 2'd0);

`ifdef IOB_BOOTROM_ROM_CTRL_CACHE_EN
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_cdata;
  logic              r_cvalid;

  assign w_hit     = w_accept & r_cvalid & (rom_raddr_i == r_tag);
  assign w_hit_dat = r_cdata;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        r_cvalid   <= 1'b0;
        r_tag      <= '0;
        r_cdata    <= '0;
        r_req_addr <= '0;
      end else begin
        if (w_miss) r_req_addr <= rom_raddr_i;
        if (w_capture) begin
          r_tag    <= r_req_addr;
          r_cdata  <= mem_rdata_i;
          r_cvalid <= 1'b1;
        end
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_dat = '0;
`endif

  assign rom_rready_o = (r_state == S_IDLE);
  assign rom_rvalid_o = r_rvalid;
  assign rom_rdata_o  = r_rdata;
  assign mem_en_o     = w_miss;
  assign mem_addr_o   = rom_raddr_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_miss) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_lat_cnt == 2'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        r_lat_cnt <= 2'd0;
        r_rvalid  <= 1'b0;
        r_rdata   <= '0;
      end else begin
        r_rvalid <= 1'b0;
        if (w_miss) r_lat_cnt <= LAT_M1;
        else if (r_state == S_BUSY && r_lat_cnt != 2'd0) r_lat_cnt <= r_lat_cnt - 2'd1;
        if (w_capture) begin
          r_rdata  <= mem_rdata_i;
          r_rvalid <= 1'b1;
        end else if (w_hit) begin
          r_rdata  <= w_hit_dat;
          r_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_bootrom_rom_ctrl.sv
// Directed bench: four controller instances (MEM_LAT 1..4) share stimulus; each has its own ROM address pipe.
// Cache scenario runs when IOB_BOOTROM_ROM_CTRL_CACHE_EN is defined, plain repeat-read otherwise.
module tb_iob_bootrom_rom_ctrl;

  logic clk = 1'b0;
  logic cke = 1'b1;
  logic rst = 1'b1;
  logic ren = 1'b0;
  logic [9:0] raddr = '0;

  logic [3:0][31:0] rdo;
  logic [3:0]       rvld;
  logic [3:0]       rrdy;
  logic [3:0]       men;
  logic [3:0][9:0]  maddr;
  logic [3:0][31:0] mrd;

  logic [31:0] rom [1024];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [9:0] aq = '0;
    iob_bootrom_rom_ctrl #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
      .clk_i       (clk),
      .cke_i       (cke),
      .rst_i       (rst),
      .rom_raddr_i (raddr),
      .rom_ren_i   (ren),
      .rom_rdata_o (rdo[g]),
      .rom_rvalid_o(rvld[g]),
      .rom_rready_o(rrdy[g]),
      .mem_en_o    (men[g]),
      .mem_addr_o  (maddr[g]),
      .mem_rdata_i (mrd[g])
    );
    always @(posedge clk) if (cke && men[g]) aq <= maddr[g];
    assign mrd[g] = rom[aq];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic rs, input logic c, input logic [9:0] a);
    ren   = r;
    rst   = rs;
    cke   = c;
    raddr = a;
    #1;
  endtask

  task automatic do_rst();
    drive(1'b0, 1'b1, 1'b1, 10'h000);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    rom[10'h005] = 32'hDEADBEEF;
    rom[10'h000] = 32'h11111111;
    rom[10'h3FF] = 32'h22222222;
    rom[10'h010] = 32'hCAFEF00D;
    rom[10'h011] = 32'h0BADC0DE;

    // Reset then idle (MEM_LAT=1)
    do_rst();
    do_rst();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 1'b1, 10'h000);
      chk("idle_rready", 32'(rrdy[0]), 32'd1);
      chk("idle_rvalid", 32'(rvld[0]), 32'd0);
      chk("idle_rdata",  rdo[0], 32'h0);
      chk("idle_men",    32'(men[0]), 32'd0);
      tick();
    end

    // Single read, MEM_LAT=2
    do_rst();
    drive(1'b1, 1'b0, 1'b1, 10'h005);
    chk("l2_c0_men",   32'(men[1]), 32'd1);
    chk("l2_c0_maddr", 32'(maddr[1]), 32'h005);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    chk("l2_c1_men",    32'(men[1]), 32'd0);
    chk("l2_c1_rready", 32'(rrdy[1]), 32'd0);
    chk("l2_c1_rvalid", 32'(rvld[1]), 32'd0);
    tick();
    chk("l2_c2_rready", 32'(rrdy[1]), 32'd0);
    chk("l2_c2_rvalid", 32'(rvld[1]), 32'd0);
    tick();
    chk("l2_c3_rvalid", 32'(rvld[1]), 32'd1);
    chk("l2_c3_rdata",  rdo[1], 32'hDEADBEEF);
    chk("l2_c3_rready", 32'(rrdy[1]), 32'd1);
    tick();
    chk("l2_c4_rvalid", 32'(rvld[1]), 32'd0);
    chk("l2_c4_rdata",  rdo[1], 32'hDEADBEEF);

    // Back-to-back, MEM_LAT=1, ren held
    do_rst();
    drive(1'b1, 1'b0, 1'b1, 10'h000);
    chk("b2b_c0_men", 32'(men[0]), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 10'h3FF);
    chk("b2b_c1_men",    32'(men[0]), 32'd0);
    chk("b2b_c1_rready", 32'(rrdy[0]), 32'd0);
    tick();
    chk("b2b_c2_rvalid", 32'(rvld[0]), 32'd1);
    chk("b2b_c2_rdata",  rdo[0], 32'h11111111);
    chk("b2b_c2_men",    32'(men[0]), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    chk("b2b_c3_rvalid", 32'(rvld[0]), 32'd0);
    tick();
    chk("b2b_c4_rvalid", 32'(rvld[0]), 32'd1);
    chk("b2b_c4_rdata",  rdo[0], 32'h22222222);
    tick();

    // Reset mid-read, MEM_LAT=4
    do_rst();
    drive(1'b1, 1'b0, 1'b1, 10'h005);
    chk("abort_c0_men", 32'(men[3]), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    chk("abort_c1_rready", 32'(rrdy[3]), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 10'h000);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    for (int c = 3; c <= 10; c++) begin
      chk("abort_rready", 32'(rrdy[3]), 32'd1);
      chk("abort_rvalid", 32'(rvld[3]), 32'd0);
      chk("abort_rdata",  rdo[3], 32'h0);
      tick();
    end

    // Reset and request together: reset wins
    drive(1'b1, 1'b1, 1'b1, 10'h005);
    chk("rst_ren_men", 32'(men[1]), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    chk("rst_ren_rready", 32'(rrdy[1]), 32'd1);
    tick();
    chk("rst_ren_rvalid", 32'(rvld[1]), 32'd0);

    // Clock-enable freeze, MEM_LAT=2
    do_rst();
    drive(1'b1, 1'b0, 1'b1, 10'h005);
    chk("cke_c0_men", 32'(men[1]), 32'd1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 10'h000);
      chk("cke_frozen_rvalid", 32'(rvld[1]), 32'd0);
      chk("cke_frozen_men",    32'(men[1]), 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    chk("cke_c4_rvalid", 32'(rvld[1]), 32'd0);
    tick();
    chk("cke_c5_rvalid", 32'(rvld[1]), 32'd0);
    tick();
    chk("cke_c6_rvalid", 32'(rvld[1]), 32'd1);
    chk("cke_c6_rdata",  rdo[1], 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 1'b0, 10'h010);
    chk("cke_idle_men",    32'(men[1]), 32'd0);
    chk("cke_idle_rvalid", 32'(rvld[1]), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    chk("cke_idle_rready", 32'(rrdy[1]), 32'd1);
    tick();

    // Repeat-read, MEM_LAT=3
    do_rst();
    drive(1'b1, 1'b0, 1'b1, 10'h010);
    chk("l3_first_men", 32'(men[2]), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    tick();
    tick();
    chk("l3_c3_rvalid", 32'(rvld[2]), 32'd0);
    tick();
    chk("l3_c4_rvalid", 32'(rvld[2]), 32'd1);
    chk("l3_c4_rdata",  rdo[2], 32'hCAFEF00D);
    drive(1'b1, 1'b0, 1'b1, 10'h010);
`ifdef IOB_BOOTROM_ROM_CTRL_CACHE_EN
    chk("hit_men", 32'(men[2]), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 10'h011);
    chk("hit_rvalid", 32'(rvld[2]), 32'd1);
    chk("hit_rdata",  rdo[2], 32'hCAFEF00D);
    chk("hit_rready", 32'(rrdy[2]), 32'd1);
    chk("miss_men",   32'(men[2]), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    chk("miss_c1_rvalid", 32'(rvld[2]), 32'd0);
    tick();
    tick();
    chk("miss_c3_rvalid", 32'(rvld[2]), 32'd0);
    tick();
    chk("miss_c4_rvalid", 32'(rvld[2]), 32'd1);
    chk("miss_c4_rdata",  rdo[2], 32'h0BADC0DE);
    tick();
    do_rst();
    drive(1'b1, 1'b0, 1'b1, 10'h010);
    chk("post_rst_men", 32'(men[2]), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
`else
    chk("rerd_men", 32'(men[2]), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 10'h000);
    chk("rerd_c1_rvalid", 32'(rvld[2]), 32'd0);
    chk("rerd_c1_rready", 32'(rrdy[2]), 32'd0);
    tick();
    tick();
    tick();
    chk("rerd_c4_rvalid", 32'(rvld[2]), 32'd1);
    chk("rerd_c4_rdata",  rdo[2], 32'hCAFEF00D);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
